pht_update_scheduler: RTL and testbench
=======================================

// Module: pht_update_scheduler
// PURPOSE
//  Owns the single-port PHT SRAM shared by the GAg/Bimodal predictors and arbitrates its port.
//  Fetch-side prediction reads contend with commit-side counter updates for that port.
//  Commit updates are buffered in a small queue and applied as read-modify-write.
//  The write uses 2-bit saturating arithmetic. Fetch has priority, except when the queue
//  is full or has starved for STARVE_LIMIT cycles; fetch then stalls.
// PARAMETERS
//  PHT_INDEX_WIDTH  11  PHT index bits (2048 entries)
//  COMMIT_WIDTH      2  update lanes accepted per cycle
//  QUEUE_DEPTH       4  buffered updates; power of 2, >= COMMIT_WIDTH
//  STARVE_LIMIT      8  consecutive fetch-won cycles with queue non-empty before update is forced
// PORTS
//  clk         in   1                           clock
//  rst         in   1                           asynchronous, active-low reset
//  upd_valid   in   COMMIT_WIDTH                per-lane commit update valid
//  upd_index   in   COMMIT_WIDTH*PHT_INDEX_WIDTH per-lane PHT index
//  upd_taken   in   COMMIT_WIDTH                per-lane resolved direction
//  upd_ready   out  1                           queue accepts a full COMMIT_WIDTH group this cycle
//  rd_req      in   1                           fetch requests prediction read
//  rd_index    in   PHT_INDEX_WIDTH             fetch read index
//  rd_grant    out  1                           fetch owns port this cycle (comb.)
//  fetch_stall out  1                           rd_req & ~rd_grant
//  pht_en      out  1                           SRAM enable
//  pht_we      out  1                           SRAM write enable
//  pht_addr    out  PHT_INDEX_WIDTH             SRAM address
//  pht_wdata   out  2                           SRAM write data
//  pht_rdata   in   2                           SRAM read data, valid 1 cycle after a read
// BEHAVIOUR
//  Reset: queue empty; FSM=IDLE; starve count=0; pht_en=pht_we=0; upd_ready=1. PHT contents untouched.
//  Reset mid-RMW drops the in-flight update; no partial write occurs.
//  Enqueue: when upd_ready, valid lanes are pushed in lane order (lane0 first).
//   Invalid lanes consume no slot. upd_ready = (free slots >= COMMIT_WIDTH).
//   The count includes a same-cycle pop.
//  FSM IDLE:
//   force = queue full | starve==STARVE_LIMIT.
//   If rd_req & ~force: rd_grant=1, pht_en=1, we=0, addr=rd_index.
//    starve++ (saturating) if queue non-empty.
//   Else if queue non-empty: read head index (en=1, we=0), rd_grant=0, starve=0, go UPD_WR.
//   Else: port idle.
//  FSM UPD_WR: rd_grant=0; pht_en=pht_we=1, addr=head index.
//   wdata = taken ? sat_inc(pht_rdata) : sat_dec(pht_rdata).
//   sat_inc(3)=3; sat_dec(0)=0. Pop head; go IDLE.
//  Update latency: 2 port cycles per update (read then write); no back-to-back RMW.
//   An IDLE cycle always follows each write.
//  Same-index updates serialize correctly: the write completes before the next RMW read.
//  Fetch read in the cycle after a write returns the new value.
//  Push and pop in the same cycle are allowed; pointers wrap modulo QUEUE_DEPTH.
// STRUCTURE
//  FetchUnitTypes package: PHT_IndexPath, PHT_CounterPath (2b), PhtUpdateEntry
//   struct {index, taken}, PHT_COUNTER_MAX/MIN constants.
//  Sub-module pht_update_queue: multi-push (COMMIT_WIDTH), single-pop circular FIFO.
//   Outputs head entry, free count and full.
//  Top holds the FSM, starve counter, port mux and saturating arithmetic.
// TESTING
//  1. Idle fetch, lane0 upd idx=5 taken, PHT[5]=1:
//     read 5, then write 2 next cycle; rd_grant=0 only in the write cycle.
//  2. Continuous rd_req, 1 queued update:
//     rd_grant=1 for 8 cycles, then forced read/write (2 stall cycles, fetch_stall=1).
//  3. Fill 4 entries with rd_req held: upd_ready=0 at full; force on next IDLE cycle.
//     upd_ready returns when free>=2.
//  4. Saturation: PHT[9]=3 taken -> 3; PHT[9]=0 not-taken -> 0.
//  5. Two lanes same idx=7, both taken, PHT[7]=1: sequential RMW ends with PHT[7]=3.
//  6. Assert rst during UPD_WR: pht_we=0 immediately, queue empty, upd_ready=1.
//     Memory entry unchanged.

Source files
------------

// File: rtl/pht_update_scheduler_pkg.sv
// rtl/pht_update_scheduler_pkg.sv - shared widths, PHT types and update entry struct
package pht_update_scheduler_pkg;
   localparam int PHT_INDEX_WIDTH = 11;
   localparam int COMMIT_WIDTH    = 2;
   localparam int QUEUE_DEPTH     = 4;
   localparam int STARVE_LIMIT    = 8;
   localparam int QPTR_WIDTH      = $clog2(QUEUE_DEPTH);

   typedef logic [PHT_INDEX_WIDTH-1:0] pht_index_path_t;
   typedef logic [1:0]                 pht_counter_path_t;

   typedef struct packed {
      pht_index_path_t index;
      logic            taken;
   } pht_update_entry_t;

   localparam pht_counter_path_t PHT_COUNTER_MAX = 2'd3;
   localparam pht_counter_path_t PHT_COUNTER_MIN = 2'd0;
endpackage

// File: rtl/pht_update_scheduler_if.sv
// rtl/pht_update_scheduler_if.sv - commit update, fetch read and PHT SRAM port bundle
interface pht_update_scheduler_if;
   import pht_update_scheduler_pkg::*;

   logic [COMMIT_WIDTH-1:0]                 upd_valid;
   logic [COMMIT_WIDTH*PHT_INDEX_WIDTH-1:0] upd_index;
   logic [COMMIT_WIDTH-1:0]                 upd_taken;
   logic                                    upd_ready;
   logic                                    rd_req;
   pht_index_path_t                         rd_index;
   logic                                    rd_grant;
   logic                                    fetch_stall;
   logic                                    pht_en;
   logic                                    pht_we;
   pht_index_path_t                         pht_addr;
   pht_counter_path_t                       pht_wdata;
   pht_counter_path_t                       pht_rdata;

   modport master (
      output upd_valid, upd_index, upd_taken, rd_req, rd_index, pht_rdata,
      input  upd_ready, rd_grant, fetch_stall, pht_en, pht_we, pht_addr, pht_wdata
   );

   modport slave (
      input  upd_valid, upd_index, upd_taken, rd_req, rd_index, pht_rdata,
      output upd_ready, rd_grant, fetch_stall, pht_en, pht_we, pht_addr, pht_wdata
   );
endinterface

// File: rtl/pht_update_scheduler_queue.sv
// rtl/pht_update_scheduler_queue.sv - multi-push, single-pop circular FIFO of PHT updates
module pht_update_queue
   import pht_update_scheduler_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [COMMIT_WIDTH-1:0] push_valid,
   input  pht_update_entry_t       push_entry [COMMIT_WIDTH],
   input  logic                    pop,
   output pht_update_entry_t       head,
   output logic [QPTR_WIDTH:0]     free_count,
   output logic                    full,
   output logic                    empty
);
   pht_update_entry_t     mem [QUEUE_DEPTH];
   logic [QPTR_WIDTH-1:0] wr_ptr;
   logic [QPTR_WIDTH-1:0] rd_ptr;
   logic [QPTR_WIDTH:0]   count;
   logic [QPTR_WIDTH:0]   push_count;
   logic [QPTR_WIDTH-1:0] slot [COMMIT_WIDTH];

   // Valid lanes pack into consecutive slots; invalid lanes are skipped.
   always_comb begin
      push_count = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         slot[i]    = wr_ptr + push_count[QPTR_WIDTH-1:0];
         push_count = push_count + {{QPTR_WIDTH{1'b0}}, push_valid[i]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + push_count[QPTR_WIDTH-1:0];
         rd_ptr <= rd_ptr + {{(QPTR_WIDTH-1){1'b0}}, pop};
         count  <= count + push_count - {{QPTR_WIDTH{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (push_valid[i]) mem[slot[i]] <= push_entry[i];
      end
   end

   assign head       = mem[rd_ptr];
   assign free_count = (QPTR_WIDTH+1)'(QUEUE_DEPTH) - count;
   assign full       = (count == (QPTR_WIDTH+1)'(QUEUE_DEPTH));
   assign empty      = (count == '0);
endmodule

// File: rtl/pht_update_scheduler.sv
// rtl/pht_update_scheduler.sv - arbitrates the single-port PHT SRAM between fetch reads and
// commit-side read-modify-write counter updates
module pht_update_scheduler
   import pht_update_scheduler_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   pht_update_scheduler_if.slave bus
);
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] UPD_WR = 1'b1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [0:0]              state, state_nxt;
   logic [STARVE_W-1:0]     starve, starve_nxt;
   pht_update_entry_t       push_entry [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0] push_valid;
   pht_update_entry_t       head;
   logic [QPTR_WIDTH:0]     free_count;
   logic                    full, empty, pop, force_upd, upd_ready;
   logic                    rd_grant, pht_en, pht_we;
   pht_index_path_t         pht_addr;
   pht_counter_path_t       pht_wdata;

   function automatic pht_counter_path_t sat_update(input pht_counter_path_t ctr,
                                                    input logic taken);
      if (taken) return (ctr == PHT_COUNTER_MAX) ? ctr : ctr + 2'd1;
      return (ctr == PHT_COUNTER_MIN) ? ctr : ctr - 2'd1;
   endfunction

   always_comb begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         push_entry[i] = '{index: bus.upd_index[i*PHT_INDEX_WIDTH +: PHT_INDEX_WIDTH],
                           taken: bus.upd_taken[i]};
      end
   end

   // A pop in this cycle frees a slot for this cycle's push group.
   assign upd_ready  = ({1'b0, free_count} + {{(QPTR_WIDTH+1){1'b0}}, pop})
                       >= (QPTR_WIDTH+2)'(COMMIT_WIDTH);
   assign push_valid = bus.upd_valid & {COMMIT_WIDTH{upd_ready}};

   pht_update_queue u_queue (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .free_count (free_count),
      .full       (full),
      .empty      (empty)
   );

   assign force_upd = full | (starve == STARVE_W'(STARVE_LIMIT));

   always_comb begin
      state_nxt  = state;
      starve_nxt = starve;
      rd_grant   = 1'b0;
      pht_en     = 1'b0;
      pht_we     = 1'b0;
      pop        = 1'b0;
      pht_addr   = head.index;
      pht_wdata  = sat_update(bus.pht_rdata, head.taken);
      case (state)
         IDLE: begin
            if (bus.rd_req && !force_upd) begin
               rd_grant = 1'b1;
               pht_en   = 1'b1;
               pht_addr = bus.rd_index;
               if (!empty && starve != STARVE_W'(STARVE_LIMIT))
                  starve_nxt = starve + STARVE_W'(1);
            end else if (!empty) begin
               pht_en     = 1'b1;
               starve_nxt = '0;
               state_nxt  = UPD_WR;
            end
         end
         UPD_WR: begin
            pht_en    = 1'b1;
            pht_we    = 1'b1;
            pop       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         starve <= '0;
      end else begin
         state  <= state_nxt;
         starve <= starve_nxt;
      end
   end

   assign bus.upd_ready   = upd_ready;
   assign bus.rd_grant    = rd_grant;
   assign bus.fetch_stall = bus.rd_req & ~rd_grant;
   assign bus.pht_en      = pht_en;
   assign bus.pht_we      = pht_we;
   assign bus.pht_addr    = pht_addr;
   assign bus.pht_wdata   = pht_wdata;
endmodule

// File: tb/tb_pht_update_scheduler.sv
// tb/tb_pht_update_scheduler.sv - directed bench for pht_update_scheduler with a PHT SRAM model
module tb_pht_update_scheduler;
   import pht_update_scheduler_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pht_update_scheduler_if bus ();

   pht_update_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [1:0]  sram [2**PHT_INDEX_WIDTH];
   logic        bd_we;
   logic [10:0] bd_addr;
   logic [1:0]  bd_data;

   // One-cycle-latency single-port SRAM; backdoor preload shares the same process.
   always @(posedge clk) begin
      if (bd_we) sram[bd_addr] <= bd_data;
      else if (bus.pht_en) begin
         if (bus.pht_we) sram[bus.pht_addr] <= bus.pht_wdata;
         else bus.pht_rdata <= sram[bus.pht_addr];
      end
   end

   int passes = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic [1:0] v, input logic [10:0] i0, input logic [10:0] i1,
                        input logic [1:0] tk, input logic rq, input logic [10:0] ri);
      @(negedge clk);
      bus.upd_valid = v;
      bus.upd_index = {i1, i0};
      bus.upd_taken = tk;
      bus.rd_req    = rq;
      bus.rd_index  = ri;
      #1;
   endtask

   task automatic idle();
      drive(2'b00, 11'd0, 11'd0, 2'b00, 1'b0, 11'd0);
   endtask

   task automatic poke(input logic [10:0] a, input logic [1:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      bus.upd_valid = '0; bus.upd_index = '0; bus.upd_taken = '0;
      bus.rd_req = 1'b0; bus.rd_index = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_upd_ready", bus.upd_ready, 1);
      chk("rst_pht_en", bus.pht_en, 0);
      chk("rst_pht_we", bus.pht_we, 0);
      chk("rst_rd_grant", bus.rd_grant, 0);
      rst = 1'b1;

      poke(11'd5, 2'd1); poke(11'd7, 2'd1); poke(11'd9, 2'd3);
      poke(11'd20, 2'd0); poke(11'd30, 2'd0); poke(11'd33, 2'd0); poke(11'd40, 2'd1);

      // 1: single update with idle fetch, then fetch sees the new value
      drive(2'b01, 11'd5, 11'd0, 2'b01, 1'b0, 11'd0);
      chk("t1_ready", bus.upd_ready, 1);
      chk("t1_push_en", bus.pht_en, 0);
      idle();
      chk("t1_rd_en", bus.pht_en, 1);
      chk("t1_rd_we", bus.pht_we, 0);
      chk("t1_rd_addr", bus.pht_addr, 5);
      idle();
      chk("t1_wr_we", bus.pht_we, 1);
      chk("t1_wr_addr", bus.pht_addr, 5);
      chk("t1_wr_data", bus.pht_wdata, 2);
      drive(2'b00, 11'd0, 11'd0, 2'b00, 1'b1, 11'd5);
      chk("t1_fetch_grant", bus.rd_grant, 1);
      chk("t1_fetch_addr", bus.pht_addr, 5);
      idle();
      chk("t1_fetch_rdata", bus.pht_rdata, 2);

      // 2: starvation forces the update after 8 fetch-won cycles
      drive(2'b01, 11'd20, 11'd0, 2'b01, 1'b1, 11'd100);
      chk("t2_push_grant", bus.rd_grant, 1);
      for (int k = 0; k < 8; k++) begin
         drive(2'b00, 11'd0, 11'd0, 2'b00, 1'b1, 11'd100);
         chk($sformatf("t2_grant_%0d", k), bus.rd_grant, 1);
      end
      drive(2'b00, 11'd0, 11'd0, 2'b00, 1'b1, 11'd100);
      chk("t2_force_grant", bus.rd_grant, 0);
      chk("t2_force_stall", bus.fetch_stall, 1);
      chk("t2_force_addr", bus.pht_addr, 20);
      chk("t2_force_we", bus.pht_we, 0);
      drive(2'b00, 11'd0, 11'd0, 2'b00, 1'b1, 11'd100);
      chk("t2_wr_stall", bus.fetch_stall, 1);
      chk("t2_wr_we", bus.pht_we, 1);
      chk("t2_wr_data", bus.pht_wdata, 1);
      drive(2'b00, 11'd0, 11'd0, 2'b00, 1'b1, 11'd100);
      chk("t2_after_grant", bus.rd_grant, 1);

      // 3: fill the queue under fetch pressure
      drive(2'b11, 11'd30, 11'd31, 2'b11, 1'b1, 11'd100);
      chk("t3_ready_a", bus.upd_ready, 1);
      chk("t3_grant_a", bus.rd_grant, 1);
      drive(2'b11, 11'd32, 11'd33, 2'b11, 1'b1, 11'd100);
      chk("t3_ready_b", bus.upd_ready, 1);
      chk("t3_grant_b", bus.rd_grant, 1);
      drive(2'b00, 11'd0, 11'd0, 2'b00, 1'b1, 11'd100);
      chk("t3_full_ready", bus.upd_ready, 0);
      chk("t3_full_grant", bus.rd_grant, 0);
      chk("t3_full_addr", bus.pht_addr, 30);
      drive(2'b00, 11'd0, 11'd0, 2'b00, 1'b1, 11'd100);
      chk("t3_wr_ready", bus.upd_ready, 0);
      chk("t3_wr_we", bus.pht_we, 1);
      idle();
      chk("t3_rd_addr", bus.pht_addr, 31);
      chk("t3_rd_ready", bus.upd_ready, 0);
      idle();
      chk("t3_ready_back", bus.upd_ready, 1);
      repeat (4) idle();
      idle();
      chk("t3_mem30", sram[30], 1);
      chk("t3_mem33", sram[33], 1);
      chk("t3_drained_en", bus.pht_en, 0);

      // 4: saturation at both ends; lane1-only push
      drive(2'b10, 11'd0, 11'd9, 2'b10, 1'b0, 11'd0);
      chk("t4_ready", bus.upd_ready, 1);
      idle();
      chk("t4_rd_addr", bus.pht_addr, 9);
      idle();
      chk("t4_inc_sat", bus.pht_wdata, 3);
      idle();
      poke(11'd9, 2'd0);
      drive(2'b01, 11'd9, 11'd0, 2'b00, 1'b0, 11'd0);
      idle();
      idle();
      chk("t4_dec_sat", bus.pht_wdata, 0);
      idle();
      chk("t4_mem9", sram[9], 0);

      // 5: same-index updates serialize
      drive(2'b11, 11'd7, 11'd7, 2'b11, 1'b0, 11'd0);
      idle();
      idle();
      chk("t5_wr1_data", bus.pht_wdata, 2);
      idle();
      chk("t5_reread_we", bus.pht_we, 0);
      chk("t5_reread_addr", bus.pht_addr, 7);
      idle();
      chk("t5_wr2_data", bus.pht_wdata, 3);
      idle();
      chk("t5_mem7", sram[7], 3);

      // 6: reset during the write cycle
      drive(2'b01, 11'd40, 11'd0, 2'b01, 1'b0, 11'd0);
      idle();
      idle();
      chk("t6_pre_we", bus.pht_we, 1);
      rst = 1'b0;
      #1;
      chk("t6_rst_we", bus.pht_we, 0);
      chk("t6_rst_ready", bus.upd_ready, 1);
      chk("t6_rst_en", bus.pht_en, 0);
      @(negedge clk);
      rst = 1'b1;
      idle();
      chk("t6_empty_en", bus.pht_en, 0);
      chk("t6_mem40", sram[40], 1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
